// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// opcode constants, instruction classes and the imm_fmt / pc_sel / wb_sel
// select codes driven to the datapath.
package multicycle_ctrl_pkg;

  // FSM states; the encoding is visible on state_o
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction classes produced by ctrl_opdecode
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_ALU_R   = 4'd1,
    CLS_ALU_I   = 4'd2,
    CLS_LUI     = 4'd3,
    CLS_AUIPC   = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_BRANCH  = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_JALR    = 4'd9,
    CLS_SYSTEM  = 4'd10
  } op_class_t;

  // RV32I major opcodes (ir[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate generator formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // PC source selects
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  // Register write-back selects
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // ALU operand B is the immediate for everything except register-register
  // arithmetic and branch compares
  function automatic logic class_uses_imm(input op_class_t cls);
    return (cls != CLS_ALU_R) && (cls != CLS_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode classifier for the multicycle controller.
// Ports:
//   opcode   - ir[6:0]
//   op_class - instruction class (CLS_ILLEGAL for any unrecognised opcode)
//   imm_fmt  - immediate generator format for this opcode
module ctrl_opdecode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_fmt
);

  // Map the major opcode to a class and its immediate format
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_fmt  = IMM_I;
    case (opcode)
      OPC_OP:     op_class = CLS_ALU_R;
      OPC_OP_IMM: op_class = CLS_ALU_I;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_SYSTEM: op_class = CLS_SYSTEM;
      OPC_STORE: begin
        op_class = CLS_STORE;
        imm_fmt  = IMM_S;
      end
      OPC_BRANCH: begin
        op_class = CLS_BRANCH;
        imm_fmt  = IMM_B;
      end
      OPC_LUI: begin
        op_class = CLS_LUI;
        imm_fmt  = IMM_U;
      end
      OPC_AUIPC: begin
        op_class = CLS_AUIPC;
        imm_fmt  = IMM_U;
      end
      OPC_JAL: begin
        op_class = CLS_JAL;
        imm_fmt  = IMM_J;
      end
      default: begin
        op_class = CLS_ILLEGAL;
        imm_fmt  = IMM_I;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- when defined, an unrecognised
// opcode halts the FSM; otherwise it executes as a NOP.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   ir                  - instruction register (valid from DECODE onward)
//   mem_ready           - memory finishes the pending access this cycle
//   br_taken            - branch comparator result, used in EXEC
//   mem_req, mem_we     - memory request / store qualifier
//   ir_we, pc_we        - IR load and PC write enables
//   pc_sel              - PC source (PC+4, PC+imm, ALU & ~1)
//   imm_fmt, alu_src_b  - datapath selects, registered at the end of DECODE
//   reg_we, wb_sel      - register file write enable and source
//   state_o, halted     - FSM state and HALT indication
// Write enables pulse for a single cycle because every state that raises one
// leaves in the same cycle. AUIPC relies on the datapath feeding PC into ALU
// operand A; this controller only selects the immediate for operand B.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_fmt,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        halted
);

  state_t     state_r, state_nxt_s;
  op_class_t  cls_r, dec_cls_s;
  logic [2:0] imm_fmt_r, dec_imm_s;
  logic       alu_src_b_r;
  logic       mem_req_s, mem_we_s, ir_we_s, pc_we_s, reg_we_s;
  logic [1:0] pc_sel_s, wb_sel_s;
  logic       unused_ir_s;

  // Only the major opcode steers the sequence
  assign unused_ir_s = ^ir[31:7];

  ctrl_opdecode u_opdecode (
    .opcode   (ir[6:0]),
    .op_class (dec_cls_s),
    .imm_fmt  (dec_imm_s)
  );

  // State register plus decode fields captured on leaving DECODE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_FETCH;
      cls_r       <= CLS_ILLEGAL;
      imm_fmt_r   <= IMM_I;
      alu_src_b_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        cls_r       <= dec_cls_s;
        imm_fmt_r   <= dec_imm_s;
        alu_src_b_r <= class_uses_imm(dec_cls_s);
      end else begin
        cls_r       <= cls_r;
        imm_fmt_r   <= imm_fmt_r;
        alu_src_b_r <= alu_src_b_r;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt_s = state_r;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    reg_we_s    = 1'b0;
    pc_sel_s    = PC_PLUS4;
    wb_sel_s    = WB_ALU;
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_we_s     = 1'b1;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_cls_s)
          CLS_SYSTEM:  state_nxt_s = ST_HALT;
`ifdef ILLEGAL_OP_TRAP_EN
          CLS_ILLEGAL: state_nxt_s = ST_HALT;
`endif
          default:     state_nxt_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_r)
          CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_AUIPC: state_nxt_s = ST_WB;
          CLS_LOAD, CLS_STORE:                      state_nxt_s = ST_MEM;
          CLS_BRANCH: begin
            pc_we_s = 1'b1;
            if (br_taken) begin
              pc_sel_s = PC_IMM;
            end else begin
              pc_sel_s = PC_PLUS4;
            end
            state_nxt_s = ST_FETCH;
          end
          CLS_JAL: begin
            reg_we_s    = 1'b1;
            wb_sel_s    = WB_PC4;
            pc_we_s     = 1'b1;
            pc_sel_s    = PC_IMM;
            state_nxt_s = ST_FETCH;
          end
          CLS_JALR: begin
            reg_we_s    = 1'b1;
            wb_sel_s    = WB_PC4;
            pc_we_s     = 1'b1;
            pc_sel_s    = PC_ALU;
            state_nxt_s = ST_FETCH;
          end
          CLS_SYSTEM: state_nxt_s = ST_HALT;
          default: begin
            // Unrecognised opcode executes as a NOP: just advance the PC
            pc_we_s     = 1'b1;
            state_nxt_s = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (cls_r == CLS_STORE);
        if (mem_ready) begin
          if (cls_r == CLS_STORE) begin
            pc_we_s     = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_we_s = 1'b1;
        pc_we_s  = 1'b1;
        case (cls_r)
          CLS_LOAD: wb_sel_s = WB_MEM;
          CLS_LUI:  wb_sel_s = WB_IMM;
          default:  wb_sel_s = WB_ALU;
        endcase
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Reset gates the Mealy outputs directly so they drop without a clock edge
  assign mem_req   = rst & mem_req_s;
  assign mem_we    = rst & mem_we_s;
  assign ir_we     = rst & ir_we_s;
  assign pc_we     = rst & pc_we_s;
  assign reg_we    = rst & reg_we_s;
  assign pc_sel    = rst ? pc_sel_s : RESET_PC_SEL;
  assign wb_sel    = rst ? wb_sel_s : WB_ALU;
  assign imm_fmt   = imm_fmt_r;
  assign alu_src_b = alu_src_b_r;
  assign state_o   = state_r;
  assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instruction per scenario, inputs
// driven on the falling edge, outputs compared 1 time unit later.
module tb_multicycle_ctrl;

  localparam logic [1:0]  RPS   = 2'd3;
  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LW    = 32'h0000_A083;
  localparam logic [31:0] I_SW    = 32'h0010_A023;
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_JAL   = 32'h0000_006F;
  localparam logic [31:0] I_JALR  = 32'h0000_8067;
  localparam logic [31:0] I_LUI   = 32'h0000_10B7;
  localparam logic [31:0] I_ADD   = 32'h0020_81B3;
  localparam logic [31:0] I_AUIPC = 32'h0000_0097;
  localparam logic [31:0] I_ILL   = 32'h0000_007F;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  logic        clk, rst, mem_ready, br_taken;
  logic [31:0] ir;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src_b, reg_we, halted;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_fmt, state_o;
  int          checks_r;
  int          errors_r;

  multicycle_ctrl #(.RESET_PC_SEL(RPS)) dut (
    .clk(clk), .rst(rst), .ir(ir), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .imm_fmt(imm_fmt), .alu_src_b(alu_src_b), .reg_we(reg_we),
    .wb_sel(wb_sel), .state_o(state_o), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge and settle
  task automatic cyc(input logic [31:0] ir_v, input logic rdy_v, input logic br_v);
    @(negedge clk);
    ir        = ir_v;
    mem_ready = rdy_v;
    br_taken  = br_v;
    #1;
  endtask

  // FETCH with memory ready, then DECODE (mem_ready held high there too)
  task automatic fetch_decode(input string tag, input logic [31:0] ir_v);
    cyc(ir_v, 1'b1, 1'b0);
    chk({tag, "_fetch_st"}, 32'(state_o), 32'd0);
    chk({tag, "_fetch_irwe"}, 32'(ir_we), 32'd1);
    cyc(ir_v, 1'b1, 1'b0);
    chk({tag, "_dec_st"}, 32'(state_o), 32'd1);
    chk({tag, "_dec_irwe"}, 32'(ir_we), 32'd0);
    chk({tag, "_dec_memreq"}, 32'(mem_req), 32'd0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_st"}, 32'(state_o), 32'd0);
    chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_irwe"}, 32'(ir_we), 32'd0);
    chk({tag, "_pcsel"}, 32'(pc_sel), 32'(RPS));
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_pcwe"}, 32'(pc_we), 32'd0);
  endtask

  // Reset pulse aligned to a falling edge
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    mem_ready = 1'b0;
    rst       = 1'b0;
    #1;
    reset_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks_r  = 0;
    errors_r  = 0;
    rst       = 1'b0;
    ir        = I_ADDI;
    mem_ready = 1'b1;
    br_taken  = 1'b0;
    #3;
    reset_outputs("rst0");
    @(negedge clk);
    #1;
    reset_outputs("rst1");
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // ADDI: 0,1,2,4
    fetch_decode("addi", I_ADDI);
    cyc(I_ADDI, 1'b1, 1'b0);
    chk("addi_ex_st", 32'(state_o), 32'd2);
    chk("addi_ex_srcb", 32'(alu_src_b), 32'd1);
    chk("addi_ex_regwe", 32'(reg_we), 32'd0);
    cyc(I_ADDI, 1'b1, 1'b0);
    chk("addi_wb_st", 32'(state_o), 32'd4);
    chk("addi_wb_regwe", 32'(reg_we), 32'd1);
    chk("addi_wb_imm", 32'(imm_fmt), 32'd0);
    chk("addi_wb_wbsel", 32'(wb_sel), 32'd0);
    chk("addi_wb_pcwe", 32'(pc_we), 32'd1);
    chk("addi_wb_pcsel", 32'(pc_sel), 32'd0);

    // LW with three wait cycles in MEM
    fetch_decode("lw", I_LW);
    cyc(I_LW, 1'b1, 1'b0);
    chk("lw_ex_st", 32'(state_o), 32'd2);
    chk("lw_ex_memreq", 32'(mem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(I_LW, 1'b0, 1'b0);
      chk("lw_wait_st", 32'(state_o), 32'd3);
      chk("lw_wait_memreq", 32'(mem_req), 32'd1);
      chk("lw_wait_memwe", 32'(mem_we), 32'd0);
    end
    cyc(I_LW, 1'b1, 1'b0);
    chk("lw_mem_memreq", 32'(mem_req), 32'd1);
    chk("lw_mem_regwe", 32'(reg_we), 32'd0);
    cyc(I_LW, 1'b1, 1'b0);
    chk("lw_wb_st", 32'(state_o), 32'd4);
    chk("lw_wb_wbsel", 32'(wb_sel), 32'd1);
    chk("lw_wb_regwe", 32'(reg_we), 32'd1);

    // SW with one FETCH wait cycle
    cyc(I_SW, 1'b0, 1'b0);
    chk("sw_fwait_st", 32'(state_o), 32'd0);
    chk("sw_fwait_memreq", 32'(mem_req), 32'd1);
    chk("sw_fwait_irwe", 32'(ir_we), 32'd0);
    fetch_decode("sw", I_SW);
    cyc(I_SW, 1'b1, 1'b0);
    chk("sw_ex_imm", 32'(imm_fmt), 32'd1);
    cyc(I_SW, 1'b1, 1'b0);
    chk("sw_mem_st", 32'(state_o), 32'd3);
    chk("sw_mem_memwe", 32'(mem_we), 32'd1);
    chk("sw_mem_pcwe", 32'(pc_we), 32'd1);
    chk("sw_mem_pcsel", 32'(pc_sel), 32'd0);
    chk("sw_mem_regwe", 32'(reg_we), 32'd0);

    // BEQ taken and not taken
    for (int t = 1; t >= 0; t--) begin
      fetch_decode("beq", I_BEQ);
      cyc(I_BEQ, 1'b1, t[0]);
      chk("beq_ex_st", 32'(state_o), 32'd2);
      chk("beq_ex_pcwe", 32'(pc_we), 32'd1);
      chk("beq_ex_pcsel", 32'(pc_sel), 32'(t[0]));
      chk("beq_ex_imm", 32'(imm_fmt), 32'd2);
      chk("beq_ex_srcb", 32'(alu_src_b), 32'd0);
    end

    // JAL
    fetch_decode("jal", I_JAL);
    cyc(I_JAL, 1'b1, 1'b0);
    chk("jal_ex_regwe", 32'(reg_we), 32'd1);
    chk("jal_ex_wbsel", 32'(wb_sel), 32'd2);
    chk("jal_ex_pcsel", 32'(pc_sel), 32'd1);
    chk("jal_ex_imm", 32'(imm_fmt), 32'd4);

    // JALR, then FETCH next cycle
    fetch_decode("jalr", I_JALR);
    cyc(I_JALR, 1'b1, 1'b0);
    chk("jalr_ex_regwe", 32'(reg_we), 32'd1);
    chk("jalr_ex_wbsel", 32'(wb_sel), 32'd2);
    chk("jalr_ex_pcsel", 32'(pc_sel), 32'd2);
    chk("jalr_ex_pcwe", 32'(pc_we), 32'd1);
    cyc(I_LUI, 1'b0, 1'b0);
    chk("jalr_next_st", 32'(state_o), 32'd0);

    // LUI
    fetch_decode("lui", I_LUI);
    cyc(I_LUI, 1'b1, 1'b0);
    chk("lui_ex_imm", 32'(imm_fmt), 32'd3);
    cyc(I_LUI, 1'b1, 1'b0);
    chk("lui_wb_wbsel", 32'(wb_sel), 32'd3);
    chk("lui_wb_regwe", 32'(reg_we), 32'd1);

    // ADD (register-register)
    fetch_decode("add", I_ADD);
    cyc(I_ADD, 1'b1, 1'b0);
    chk("add_ex_srcb", 32'(alu_src_b), 32'd0);
    chk("add_ex_imm", 32'(imm_fmt), 32'd0);
    cyc(I_ADD, 1'b1, 1'b0);
    chk("add_wb_st", 32'(state_o), 32'd4);
    chk("add_wb_regwe", 32'(reg_we), 32'd1);

    // AUIPC
    fetch_decode("auipc", I_AUIPC);
    cyc(I_AUIPC, 1'b1, 1'b0);
    chk("auipc_ex_srcb", 32'(alu_src_b), 32'd1);
    chk("auipc_ex_imm", 32'(imm_fmt), 32'd3);
    cyc(I_AUIPC, 1'b1, 1'b0);
    chk("auipc_wb_wbsel", 32'(wb_sel), 32'd0);
    chk("auipc_wb_regwe", 32'(reg_we), 32'd1);

    // Unrecognised opcode 7'h7F
    fetch_decode("ill", I_ILL);
    cyc(I_ILL, 1'b1, 1'b0);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_st", 32'(state_o), 32'd5);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_memreq", 32'(mem_req), 32'd0);
    pulse_reset("ill_rst");
`else
    chk("ill_ex_st", 32'(state_o), 32'd2);
    chk("ill_ex_pcwe", 32'(pc_we), 32'd1);
    chk("ill_ex_pcsel", 32'(pc_sel), 32'd0);
    chk("ill_ex_regwe", 32'(reg_we), 32'd0);
    cyc(I_ILL, 1'b0, 1'b0);
    chk("ill_next_st", 32'(state_o), 32'd0);
`endif

    // ECALL halts permanently, mem_ready toggling is ignored
    fetch_decode("ecall", I_ECALL);
    for (int i = 0; i < 4; i++) begin
      cyc(I_ECALL, i[0], 1'b1);
      chk("ecall_st", 32'(state_o), 32'd5);
      chk("ecall_halted", 32'(halted), 32'd1);
      chk("ecall_memreq", 32'(mem_req), 32'd0);
      chk("ecall_pcwe", 32'(pc_we), 32'd0);
      chk("ecall_regwe", 32'(reg_we), 32'd0);
    end
    pulse_reset("halt_rst");

    // Reset asserted between clock edges while FETCH waits
    cyc(I_ADDI, 1'b0, 1'b0);
    chk("fwait_memreq", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_memreq", 32'(mem_req), 32'd0);
    chk("async_pcsel", 32'(pc_sel), 32'(RPS));
    @(negedge clk);
    rst = 1'b1;
    cyc(I_ADDI, 1'b1, 1'b0);
    chk("restart_st", 32'(state_o), 32'd0);
    chk("restart_irwe", 32'(ir_we), 32'd1);
    cyc(I_ADDI, 1'b1, 1'b0);
    chk("restart_dec_st", 32'(state_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
